// File: rtl/datapath_sequencer_if.sv
// Handshake and datapath-control bundle for datapath_sequencer.
// The retired_count signal exists only when SEQ_PERF_COUNT_EN is defined.
interface datapath_sequencer_if #(
    parameter int INSTR_W    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 4,
    parameter int CNT_W      = 32
);
    logic                  instr_valid;
    logic [INSTR_W-1:0]    instr;
    logic                  instr_ready;
    logic [REG_ADDR_W-1:0] read_reg1;
    logic [REG_ADDR_W-1:0] read_reg2;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [CTRL_W-1:0]     alu_control;
    logic                  write_on_register;
    logic                  zero_flag;
    logic                  done_valid;
    logic                  done_ready;
    logic                  done_zero;
    logic                  done_illegal;
    logic                  busy;
`ifdef SEQ_PERF_COUNT_EN
    logic [CNT_W-1:0]      retired_count;
`endif

    // slave is the sequencer; master is the instruction source, datapath and status consumer
    modport slave (
`ifdef SEQ_PERF_COUNT_EN
        output retired_count,
`endif
        input  instr_valid, instr, zero_flag, done_ready,
        output instr_ready, read_reg1, read_reg2, write_reg, alu_control,
        output write_on_register, done_valid, done_zero, done_illegal, busy
    );

    modport master (
`ifdef SEQ_PERF_COUNT_EN
        input  retired_count,
`endif
        output instr_valid, instr, zero_flag, done_ready,
        input  instr_ready, read_reg1, read_reg2, write_reg, alu_control,
        input  write_on_register, done_valid, done_zero, done_illegal, busy
    );
endinterface

// File: rtl/datapath_sequencer.sv
// One-at-a-time R-type sequencer in front of the register-file/ALU datapath.
// Optional feature: define SEQ_PERF_COUNT_EN to add the retired-instruction counter.
module datapath_sequencer #(
    parameter int INSTR_W    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 4,
    parameter int CNT_W      = 32
) (
    input logic                  clk,
    input logic                  reset,
    datapath_sequencer_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [6:0] OPCODE_R = 7'b0110011;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  accept;
    logic                  done_fire;
    logic [CTRL_W-1:0]     alu_dec;
    logic                  legal_dec;
    logic [REG_ADDR_W-1:0] rs1_q;
    logic [REG_ADDR_W-1:0] rs2_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [CTRL_W-1:0]     alu_q;
    logic                  legal_q;
    logic                  zero_q;
    logic                  illegal_q;

    assign accept    = bus.instr_valid & bus.instr_ready;
    assign done_fire = (state == DONE) & bus.done_ready;

    always_comb begin
        alu_dec   = '0;
        legal_dec = 1'b0;
        if (bus.instr[6:0] == OPCODE_R) begin
            legal_dec = 1'b1;
            case ({bus.instr[31:25], bus.instr[14:12]})
                {7'b0000000, 3'b000}: alu_dec = CTRL_W'(4'b0010);
                {7'b0100000, 3'b000}: alu_dec = CTRL_W'(4'b0110);
                {7'b0000000, 3'b111}: alu_dec = CTRL_W'(4'b0000);
                {7'b0000000, 3'b110}: alu_dec = CTRL_W'(4'b0001);
                {7'b0000000, 3'b100}: alu_dec = CTRL_W'(4'b0011);
                {7'b0000000, 3'b010}: alu_dec = CTRL_W'(4'b0111);
                {7'b0000000, 3'b001}: alu_dec = CTRL_W'(4'b1000);
                {7'b0000000, 3'b101}: alu_dec = CTRL_W'(4'b1001);
                {7'b0100000, 3'b101}: alu_dec = CTRL_W'(4'b1010);
                default: begin
                    alu_dec   = '0;
                    legal_dec = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    if (bus.done_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Decode happens at acceptance so EXEC drives purely from registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
            legal_q <= 1'b0;
        end else if (accept) begin
            rs1_q   <= bus.instr[19:15];
            rs2_q   <= bus.instr[24:20];
            rd_q    <= bus.instr[11:7];
            alu_q   <= alu_dec;
            legal_q <= legal_dec;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (state == EXEC) begin
            zero_q    <= bus.zero_flag;
            illegal_q <= ~legal_q;
        end
    end

`ifdef SEQ_PERF_COUNT_EN
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (done_fire && !illegal_q) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign bus.retired_count = retired_q;
`endif

    assign bus.instr_ready       = (state == IDLE);
    assign bus.busy              = (state != IDLE);
    assign bus.done_valid        = (state == DONE);
    assign bus.done_zero         = zero_q;
    assign bus.done_illegal      = illegal_q;
    assign bus.read_reg1         = rs1_q;
    assign bus.read_reg2         = rs2_q;
    assign bus.write_reg         = rd_q;
    assign bus.alu_control       = alu_q;
    assign bus.write_on_register = (state == EXEC) & legal_q & (rd_q != '0);
endmodule
